// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC sequencing and a request/ack handshake
// to instruction memory. Optional misaligned-target trap: FETCH_MISALIGN_TRAP_EN.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        pcsrc,
  input  logic [31:0] imm_ext,
  input  logic        stall,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  output logic        misalign
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD,
    TRAP
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] next;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic        mis_q, mis_d;
`endif

  assign next = pcsrc ? (pc_q + imm_ext)
                      : (pc_q + 32'd4);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    mis_d   = mis_q;
`endif
    unique case (state_q)
      IDLE: begin
        state_d = REQ;
        addr_d  = RESET_PC;
      end
      REQ: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          pc_d    = addr_q;
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (!stall) begin
          valid_d = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
          if (next[1:0] != 2'b00) begin
            mis_d   = 1'b1;
            state_d = TRAP;
          end else begin
            addr_d  = next;
            state_d = REQ;
          end
`else
          addr_d  = next & ~32'h3;
          state_d = REQ;
`endif
        end
      end
      TRAP: begin
        state_d = TRAP;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= RESET_PC;
      instr_q <= NOP;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      mis_q   <= mis_d;
`endif
    end
  end

  assign imem_req    = (state_q == REQ);
  assign imem_addr   = addr_q;
  assign instr       = instr_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign instr_valid = valid_q;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign misalign    = mis_q;
`else
  assign misalign    = 1'b0;
`endif

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port imem_req, output, 1 bit: fetch request to instruction memory.
REQ-005 The block SHALL have port imem_addr, output, 32 bits: fetch address, valid while imem_req=1.
REQ-006 The block SHALL have port imem_ack, input, 1 bit: memory indicates imem_rdata is valid this cycle.
REQ-007 The block SHALL have port imem_rdata, input, 32 bits: fetched instruction word.
REQ-008 The block SHALL have port pcsrc, input, 1 bit: 1 selects the branch/jump target for the next PC.
REQ-009 The block SHALL have port imm_ext, input, 32 bits: sign-extended immediate from the extender stage.
REQ-010 The block SHALL have port stall, input, 1 bit: downstream not ready; hold the current instruction.
REQ-011 The block SHALL have port instr, output, 32 bits: registered instruction, fed to decode and the immediate extender.
REQ-012 The block SHALL have port pc, output, 32 bits: address of instr.
REQ-013 The block SHALL have port pc_plus4, output, 32 bits: pc+4, combinational from pc.
REQ-014 The block SHALL have port instr_valid, output, 1 bit: instr/pc hold a fetched instruction.
REQ-015 The block SHALL have port misalign, output, 1 bit: sticky misaligned-target flag (see Configuration).

Function
REQ-016 The FSM SHALL have states IDLE, REQ, HOLD and TRAP.
REQ-017 IDLE SHALL last exactly one cycle after reset deasserts, then go to REQ with fetch address RESET_PC.
REQ-018 In REQ, the block SHALL drive imem_req=1 and hold imem_addr stable until imem_ack=1.
REQ-019 In REQ with imem_ack=1, the block SHALL latch imem_rdata into instr and the fetch address into pc, set instr_valid=1 on the next edge, and go to HOLD.
REQ-020 An ack in the same cycle as the request SHALL be accepted, giving one-cycle fetch latency from imem_req rising to instr_valid rising.
REQ-021 The block SHALL ignore imem_ack whenever it is not in REQ.
REQ-022 In HOLD with stall=1, instr, pc and instr_valid SHALL hold unchanged and imem_req SHALL be 0.
REQ-023 In HOLD with stall=0, the block SHALL sample pcsrc and imm_ext, compute next = pcsrc ? pc+imm_ext : pc+4, clear instr_valid on the next edge and go to REQ with imem_addr=next.
REQ-024 All PC arithmetic SHALL be modulo 2^32 (wrap-around, no overflow flag).
REQ-025 While in REQ, instr_valid SHALL be 0, and pcsrc and stall SHALL be ignored.

Reset
REQ-026 reset=1 at a rising edge SHALL force state IDLE, imem_req=0, imem_addr=RESET_PC, instr=32'h0000_0013 (NOP), pc=RESET_PC, instr_valid=0 and misalign=0.
REQ-027 Reset asserted mid-fetch SHALL abandon the outstanding request, dropping imem_req at that edge, and any later ack for it SHALL be ignored.

Configuration
REQ-028 When macro FETCH_MISALIGN_TRAP_EN is defined, a computed target with next[1:0]!=2'b00 SHALL set misalign=1, keep imem_req=0 and move the FSM to TRAP, which exits only on reset.
REQ-029 When macro FETCH_MISALIGN_TRAP_EN is undefined, next[1:0] SHALL be forced to 2'b00 before fetching, misalign SHALL be constant 0 and TRAP SHALL be unreachable.

Verification
REQ-030 Scenario: reset, then memory acks immediately -> imem_addr=0x0 at the first request, instr_valid=1 one cycle later, pc=0x0.
REQ-031 Scenario: stall=0, pcsrc=0, pc=0x100 -> next request at 0x104; with 3 wait cycles before ack, imem_addr holds 0x104 for all 4 request cycles.
REQ-032 Scenario: pc=0x200, pcsrc=1, imm_ext=0xFFFFFFF0 -> next fetch at 0x1F0.
REQ-033 Scenario: stall=1 for 5 cycles in HOLD -> instr/pc unchanged, imem_req=0 throughout; a spurious ack in HOLD changes nothing.
REQ-034 Scenario: pc=0xFFFFFFFC, pcsrc=0 -> next fetch at 0x00000000.
REQ-035 Scenario: pcsrc=1, imm_ext=0x6 at pc=0x40 -> with the macro, misalign=1, FSM in TRAP, no request; without it, fetch at 0x44; a reset asserted during a pending fetch drops imem_req on that edge and restores the REQ-026 values.
